// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module : video_pkg
// Brief  : Shared pixel types, default 1280x1024@60 timing, palette and
//          built-in tile-set helpers for the tile video engine.
// Rev    : 1.0
// ============================================================================
package video_pkg;

    typedef logic [11:0] rgb12_t;

    // Pixel context carried alongside the data through the render pipeline.
    typedef struct packed {
        logic [10:0] col;
        logic [10:0] row;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        fs;
    } pix_ctx_t;

    localparam int c_HD = 1280;
    localparam int c_HF = 48;
    localparam int c_HR = 112;
    localparam int c_HB = 248;
    localparam int c_VD = 1024;
    localparam int c_VF = 1;
    localparam int c_VR = 3;
    localparam int c_VB = 38;

    function automatic rgb12_t pal_lookup(input logic [1:0] idx,
                                          input rgb12_t p0, input rgb12_t p1,
                                          input rgb12_t p2, input rgb12_t p3);
        rgb12_t rgb;
        case (idx)
            2'd0:    rgb = p0;
            2'd1:    rgb = p1;
            2'd2:    rgb = p2;
            default: rgb = p3;
        endcase
        return rgb;
    endfunction

    // Built-in 8x8 tile set, repeating every 4 types:
    // empty, solid wall, two-band wall (index 2 over index 1), checkerboard.
    function automatic logic [1:0] tile_texel(input int unsigned tileType,
                                              input logic [2:0] r,
                                              input logic [2:0] c);
        logic [1:0] idx;
        case (tileType % 4)
            0:       idx = 2'd0;
            1:       idx = 2'd1;
            2:       idx = (r < 3'd4) ? 2'd2 : 2'd1;
            default: idx = (^(r ^ c)) ? 2'd2 : 2'd0;
        endcase
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : video_timing_gen
// Brief  : Stage-1 pixel/line counters, frame-end tick and raw sync/blank decode.
// Rev    : 1.0
// ============================================================================
module video_timing_gen #(
    parameter int HD = 1280,
    parameter int HF = 48,
    parameter int HR = 112,
    parameter int HB = 248,
    parameter int VD = 1024,
    parameter int VF = 1,
    parameter int VR = 3,
    parameter int VB = 38
) (
    input  logic        clk,
    input  logic        resetN,
    output logic [10:0] o_col,
    output logic [10:0] o_row,
    output logic        o_frameEnd,
    output logic        o_hsRaw,
    output logic        o_vsRaw,
    output logic        o_blankRaw,
    output logic        o_fsRaw
);
    localparam logic [10:0] c_H_LAST = 11'(HD + HF + HR + HB - 1);
    localparam logic [10:0] c_V_LAST = 11'(VD + VF + VR + VB - 1);
    localparam logic [10:0] c_HD     = 11'(HD);
    localparam logic [10:0] c_VD     = 11'(VD);
    localparam logic [10:0] c_HS_ON  = 11'(HD + HF);
    localparam logic [10:0] c_HS_OFF = 11'(HD + HF + HR);
    localparam logic [10:0] c_VS_ON  = 11'(VD + VF);
    localparam logic [10:0] c_VS_OFF = 11'(VD + VF + VR);

    logic [10:0] r_col;
    logic [10:0] r_row;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_col == c_H_LAST) begin
            r_col <= '0;
            r_row <= (r_row == c_V_LAST) ? 11'd0 : r_row + 11'd1;
        end else begin
            r_col <= r_col + 11'd1;
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_frameEnd = (r_col == c_H_LAST) && (r_row == c_V_LAST);
    assign o_hsRaw    = (r_col >= c_HS_ON) && (r_col < c_HS_OFF);
    assign o_vsRaw    = (r_row >= c_VS_ON) && (r_row < c_VS_OFF);
    assign o_blankRaw = (r_col >= c_HD) || (r_row >= c_VD);
    assign o_fsRaw    = (r_row == c_VD) && (r_col == 11'd0);

endmodule
`default_nettype wire

// File: rtl/tile_video_engine.sv
`default_nettype none
// ============================================================================
// Module : tile_video_engine
// Brief  : Tile-map VGA renderer with writable map, optional ball sprite
//          (SPRITE_OVERLAY_EN) and frame-start strobe; 4-clock pixel latency.
// Rev    : 1.0
// ============================================================================
module tile_video_engine
    import video_pkg::*;
#(
    parameter int     HD        = c_HD,
    parameter int     HF        = c_HF,
    parameter int     HR        = c_HR,
    parameter int     HB        = c_HB,
    parameter int     VD        = c_VD,
    parameter int     VF        = c_VF,
    parameter int     VR        = c_VR,
    parameter int     VB        = c_VB,
    parameter int     TILE_LOG2 = 5,
    parameter int     MAP_LOG2  = 5,
    parameter int     TYPE_W    = 6,
    parameter int     X_LO      = 64,
    parameter int     X_HI      = 960,
    parameter rgb12_t PAL0      = 12'h000,
    parameter rgb12_t PAL1      = 12'h00F,
    parameter rgb12_t PAL2      = 12'hFCA,
    parameter rgb12_t PAL3      = 12'h000,
    parameter int     SPR_SIZE  = 16,
    parameter rgb12_t SPR_RGB   = 12'hFFF,
    parameter logic [SPR_SIZE*SPR_SIZE-1:0] SPR_MASK = '1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  mapWe,
    input  logic [2*MAP_LOG2-1:0] mapWaddr,
    input  logic [TYPE_W-1:0]     mapWdata,
    input  logic [10:0]           ballX,
    input  logic [10:0]           ballY,
    output logic                  frameStart,
    output logic                  VGA_HS,
    output logic                  VGA_VS,
    output logic [3:0]            VGA_R,
    output logic [3:0]            VGA_G,
    output logic [3:0]            VGA_B
);
    localparam int          c_MAP_DEPTH = 2 ** (2 * MAP_LOG2);
    localparam logic [10:0] c_X_LO      = 11'(X_LO);
    localparam logic [10:0] c_X_HI      = 11'(X_HI);

    pix_ctx_t w_s1, r_s2, r_s3, r_s4;
    logic     w_frameEnd;

    video_timing_gen #(
        .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB)
    ) u_timing (
        .clk        (clk),
        .resetN     (resetN),
        .o_col      (w_s1.col),
        .o_row      (w_s1.row),
        .o_frameEnd (w_frameEnd),
        .o_hsRaw    (w_s1.hs),
        .o_vsRaw    (w_s1.vs),
        .o_blankRaw (w_s1.blank),
        .o_fsRaw    (w_s1.fs)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_s2 <= '0;
            r_s3 <= '0;
            r_s4 <= '0;
        end else begin
            r_s2 <= w_s1;
            r_s3 <= r_s2;
            r_s4 <= r_s3;
        end
    end

    // Map RAM: not reset so game state survives; read-before-write on collision.
    logic [TYPE_W-1:0]     r_mapMem [c_MAP_DEPTH];
    logic [TYPE_W-1:0]     r_tileType;
    logic [2*MAP_LOG2-1:0] w_mapRaddr;

    assign w_mapRaddr = {w_s1.row[TILE_LOG2+MAP_LOG2-1:TILE_LOG2],
                         w_s1.col[TILE_LOG2+MAP_LOG2-1:TILE_LOG2]};

    always_ff @(posedge clk) begin
        if (mapWe) begin
            r_mapMem[mapWaddr] <= mapWdata;
        end
        r_tileType <= r_mapMem[w_mapRaddr];
    end

    logic [1:0] r_pixIdx;
    rgb12_t     r_palRgb;

    always_ff @(posedge clk) begin
        r_pixIdx <= tile_texel(32'(r_tileType),
                               r_s2.row[TILE_LOG2-1:TILE_LOG2-3],
                               r_s2.col[TILE_LOG2-1:TILE_LOG2-3]);
        r_palRgb <= pal_lookup(r_pixIdx, PAL0, PAL1, PAL2, PAL3);
    end

    logic   w_sprHit;
    rgb12_t w_sprRgb;

`ifdef SPRITE_OVERLAY_EN
    localparam int          c_SPR_IW   = (SPR_SIZE * SPR_SIZE > 1) ? $clog2(SPR_SIZE * SPR_SIZE) : 1;
    localparam logic [10:0] c_SPR_EDGE = 11'(SPR_SIZE);

    logic [10:0]         r_shX, r_shY;
    logic [10:0]         w_dx, w_dy;
    logic [c_SPR_IW-1:0] w_sprIdx;
    logic                r_sprHit;

    // Wrapping subtraction: positions left/above the sprite become large and fail the edge test.
    assign w_dx     = r_s3.col - r_shX;
    assign w_dy     = r_s3.row - r_shY;
    assign w_sprIdx = c_SPR_IW'(int'(w_dy) * SPR_SIZE + int'(w_dx));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_shX    <= '0;
            r_shY    <= '0;
            r_sprHit <= 1'b0;
        end else begin
            if (w_frameEnd) begin
                r_shX <= ballX;
                r_shY <= ballY;
            end
            r_sprHit <= (w_dx < c_SPR_EDGE) && (w_dy < c_SPR_EDGE) && SPR_MASK[w_sprIdx];
        end
    end

    assign w_sprHit = r_sprHit;
    assign w_sprRgb = SPR_RGB;
`else
    localparam logic c_unusedSprCfg = (^{SPR_RGB, SPR_MASK}) ^ (SPR_SIZE > 0);
    logic w_unusedBall;

    assign w_unusedBall = ^{ballX, ballY, w_frameEnd, r_s3.row};
    assign w_sprHit     = 1'b0;
    assign w_sprRgb     = 12'h000;
`endif

    logic   w_black;
    logic   w_unusedRow4;
    rgb12_t w_pixRgb;

    assign w_unusedRow4 = ^r_s4.row;
    assign w_black  = r_s4.blank || (r_s4.col <= c_X_LO) || (r_s4.col >= c_X_HI);
    assign w_pixRgb = w_black ? 12'h000 : (w_sprHit ? w_sprRgb : r_palRgb);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            VGA_R      <= '0;
            VGA_G      <= '0;
            VGA_B      <= '0;
            VGA_HS     <= 1'b0;
            VGA_VS     <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            VGA_R      <= w_pixRgb[11:8];
            VGA_G      <= w_pixRgb[7:4];
            VGA_B      <= w_pixRgb[3:0];
            VGA_HS     <= r_s4.hs;
            VGA_VS     <= r_s4.vs;
            frameStart <= r_s4.fs;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_video_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_tile_video_engine
// Brief  : Directed self-checking bench on a reduced 64x48 raster with 8-px tiles.
// Rev    : 1.0
// ============================================================================
module tb_tile_video_engine;
    localparam int HD = 64, HF = 4, HR = 8, HB = 4;
    localparam int VD = 48, VF = 2, VR = 3, VB = 3;
    localparam int HT = 80, VT = 56, FRAME = HT * VT;
    localparam int LAT = 4;

`ifdef SPRITE_OVERLAY_EN
    localparam logic [11:0] c_SPR_EXP = 12'hFFF;
`else
    localparam logic [11:0] c_SPR_EXP = 12'hFCA;
`endif

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        mapWe = 1'b0;
    logic [5:0]  mapWaddr = '0;
    logic [5:0]  mapWdata = '0;
    logic [10:0] ballX = '0;
    logic [10:0] ballY = '0;
    logic        frameStart, VGA_HS, VGA_VS;
    logic [3:0]  VGA_R, VGA_G, VGA_B;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    tile_video_engine #(
        .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB),
        .TILE_LOG2(3), .MAP_LOG2(3), .TYPE_W(6),
        .X_LO(8), .X_HI(56), .SPR_SIZE(4), .SPR_RGB(12'hFFF)
    ) dut (
        .clk(clk), .resetN(resetN),
        .mapWe(mapWe), .mapWaddr(mapWaddr), .mapWdata(mapWdata),
        .ballX(ballX), .ballY(ballY),
        .frameStart(frameStart), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #5 clk = ~clk;

    function automatic int pix(input int f, input int c, input int r);
        return f * FRAME + r * HT + c;
    endfunction

    task automatic goTo(input int k);
        if (cyc < k) begin
            while (cyc < k) begin
                @(posedge clk);
                cyc++;
            end
            #1;
        end
    endtask

    task automatic chkRgb(input string tag, input logic [11:0] exp);
        logic [11:0] obs;
        obs = {VGA_R, VGA_G, VGA_B};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkBit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkInt(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output for stage-1 pixel p is valid right after clock p+LAT.
    task automatic seeRgb(input string tag, input int p, input logic [11:0] exp);
        goTo(p + LAT);
        chkRgb(tag, exp);
    endtask

    task automatic mapWrite(input int p, input logic [5:0] addr, input logic [5:0] data);
        goTo(p);
        mapWe    = 1'b1;
        mapWaddr = addr;
        mapWdata = data;
        goTo(p + 1);
        mapWe    = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chkRgb("reset_rgb", 12'h000);
        chkBit("reset_hs", VGA_HS, 1'b0);
        chkBit("reset_vs", VGA_VS, 1'b0);
        chkBit("reset_fs", frameStart, 1'b0);

        ballX  = 11'd12;
        ballY  = 11'd40;
        resetN = 1'b1;
        cyc    = 0;

        // Map: type 2 banded wall everywhere, checkerboard at {row2,col3}.
        for (int i = 0; i < 64; i++) begin
            mapWe    = 1'b1;
            mapWaddr = i[5:0];
            mapWdata = (i == 2 * 8 + 3) ? 6'd3 : 6'd2;
            goTo(cyc + 1);
        end
        mapWe = 1'b0;

        while (VGA_HS !== 1'b1 && cyc < 300) goTo(cyc + 1);
        chkInt("hs_first_rise", cyc, HD + HF + LAT);
        t0 = cyc;
        while (VGA_HS === 1'b1 && cyc < t0 + 200) goTo(cyc + 1);
        chkInt("hs_width", cyc - t0, HR);

        goTo(pix(0, 0, VD) + LAT - 1);
        chkBit("fs_before", frameStart, 1'b0);
        goTo(pix(0, 0, VD) + LAT);
        chkBit("fs_pulse", frameStart, 1'b1);
        goTo(pix(0, 0, VD) + LAT + 1);
        chkBit("fs_after", frameStart, 1'b0);

        goTo(pix(0, HT - 1, VD + VF - 1) + LAT);
        chkBit("vs_before", VGA_VS, 1'b0);
        goTo(pix(0, 0, VD + VF) + LAT);
        chkBit("vs_rise", VGA_VS, 1'b1);
        goTo(pix(0, HT - 1, VD + VF + VR - 1) + LAT);
        chkBit("vs_last", VGA_VS, 1'b1);
        goTo(pix(0, 0, VD + VF + VR) + LAT);
        chkBit("vs_fall", VGA_VS, 1'b0);

        t0 = pix(0, 0, VD) + LAT;
        while (frameStart !== 1'b1 && cyc < t0 + 6000) goTo(cyc + 1);
        chkInt("frame_period", cyc - t0, FRAME);

        // Frame 2: tiles, window edges, map writes, sprite at (12,40).
        seeRgb("x_lo_black",   pix(2, 8, 0),   12'h000);
        seeRgb("x_lo_plus1",   pix(2, 9, 0),   12'hFCA);
        seeRgb("x_hi_minus1",  pix(2, 55, 0),  12'hFCA);
        seeRgb("x_hi_black",   pix(2, 56, 0),  12'h000);
        seeRgb("band_top",     pix(2, 20, 10), 12'hFCA);
        seeRgb("band_bottom",  pix(2, 20, 13), 12'h00F);
        seeRgb("checker_00",   pix(2, 24, 16), 12'h000);
        seeRgb("checker_01",   pix(2, 25, 16), 12'hFCA);
        seeRgb("checker_03",   pix(2, 27, 16), 12'h000);
        seeRgb("checker_10",   pix(2, 24, 17), 12'hFCA);
        mapWrite(pix(2, 0, 20), {3'd3, 3'd4}, 6'd1);
        seeRgb("map_wr_new",   pix(2, 36, 26), 12'h00F);
        seeRgb("map_wr_other", pix(2, 44, 26), 12'hFCA);
        goTo(pix(2, 0, 30));
        ballX = 11'd20;
        mapWrite(pix(2, 40, 34), {3'd4, 3'd5}, 6'd1);
        seeRgb("same_cyc_old", pix(2, 40, 34), 12'hFCA);
        seeRgb("same_cyc_new", pix(2, 41, 34), 12'h00F);
        seeRgb("spr_tl",       pix(2, 12, 40), c_SPR_EXP);
        seeRgb("spr_tr",       pix(2, 15, 40), c_SPR_EXP);
        seeRgb("spr_right",    pix(2, 16, 40), 12'hFCA);
        seeRgb("spr_not_yet",  pix(2, 20, 40), 12'hFCA);
        seeRgb("spr_br",       pix(2, 15, 43), c_SPR_EXP);
        seeRgb("spr_below",    pix(2, 12, 44), 12'h00F);
        seeRgb("row_vd_black", pix(2, 20, VD), 12'h000);

        // Frame 3: moved sprite takes effect only now.
        seeRgb("map_persist",  pix(3, 36, 26), 12'h00F);
        seeRgb("spr_old_gone", pix(3, 12, 40), 12'hFCA);
        seeRgb("spr_new_tl",   pix(3, 20, 40), c_SPR_EXP);
        seeRgb("spr_new_tr",   pix(3, 23, 40), c_SPR_EXP);
        seeRgb("spr_new_right", pix(3, 24, 40), 12'hFCA);
        seeRgb("spr_new_br",   pix(3, 23, 43), c_SPR_EXP);

        // Asynchronous reset mid-line, then restart from pixel (0,0).
        seeRgb("pre_reset",    pix(4, 20, 10), 12'hFCA);
        resetN = 1'b0;
        #1;
        chkRgb("async_reset_rgb", 12'h000);
        chkBit("async_reset_hs", VGA_HS, 1'b0);
        chkBit("async_reset_fs", frameStart, 1'b0);
        #3;
        resetN = 1'b1;
        cyc    = 0;
        seeRgb("restart_row0", pix(0, 9, 0), 12'hFCA);
        while (VGA_HS !== 1'b1 && cyc < 300) goTo(cyc + 1);
        chkInt("restart_hs_rise", cyc, HD + HF + LAT);
        seeRgb("map_retained", pix(0, 36, 26), 12'h00F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
